axis_crc_strip: RTL and testbench
=================================

# axis_crc_strip

Receive-side companion to the 512-bit AXI-ST CRC appender. It removes the 4-byte CRC trailer that the appender stitched onto the end of each packet and presents that CRC as a 32-bit sideband value alongside the last output beat. The last output beat's `tkeep` is trimmed so the payload ends exactly at its original byte. The block sits in the RX path between the link deframer and the CRC checker. When the trailer straddles a beat boundary, it holds one beat of lookahead to retire the packet one beat early.

## Interface
Parameters:
- `DATA_W`, 512: data width in bits; fixed at 512 in this block.
- `KEEP_W`, 64: `DATA_W/8`, the byte-enable width.

Ports:
- `clock` in 1: single clock.
- `arst_n` in 1: asynchronous, active-low reset.
- `i_tdata` in 512, `i_tkeep` in 64, `i_tlast` in 1, `i_tvalid` in 1: input stream. Byte 0 is bits [7:0].
- `i_tready` out 1: backpressure to the source.
- `o_tdata` out 512, `o_tkeep` out 64, `o_tlast` out 1, `o_tvalid` out 1: output stream with the CRC trailer removed.
- `o_tready` in 1: backpressure from the sink.
- `o_crc` out 32: extracted CRC. It is valid only when `o_tvalid && o_tlast`. CRC0 sits in [7:0].
- `o_runt` out 1: one-cycle pulse when a packet is accepted and dropped because its total length is ≤4 bytes.
- `o_keep_err` out 1: sticky keep-format error; present only with the macro described under Configuration.

## Operation
- Input rules: non-last beats carry `tkeep` of all ones. A last beat carries contiguous `tkeep` from bit 0 with count k in 1..64.
- Hold register H stores `{data, keep, last, valid}`.
- The output is driven combinationally from H, using the incoming beat I as lookahead.
- When `o_tvalid` is 0, `o_tkeep`, `o_tlast` and `o_crc` are forced to 0. `o_tdata` reflects H.

Cases, evaluated each cycle:
- **Case A, H empty:**
  - `o_tvalid=0`, `i_tready=1`.
  - An accepted I is loaded into H, except when I is a single-beat packet with k≤4 (see Case E).
- **Case B, H valid, H not last, no I valid:**
  - `o_tvalid=0`, waiting for lookahead.
  - `i_tready=1`.
- **Case C, H valid, H not last, I valid, and not (`i_tlast` with k≤4):**
  - Output is H unchanged, with `o_tlast=0`.
  - `i_tready=o_tready`. On handshake, I replaces H.
- **Case D, H valid, H not last, I valid, `i_tlast` with k≤4 (CRC straddles or fills I):**
  - Output is H with `o_tlast=1` and `o_tkeep` = ones in bits [63-(4-k):0].
  - `o_crc` = {I bytes k-1..0, H bytes 63..64-(4-k)}, with the H bytes in the low positions.
  - `i_tready=o_tready`. On handshake, I is consumed and discarded, and H becomes empty.
- **Case E, single-beat packet with k≤4:**
  - Applies when I is both the first beat of a packet and `i_tlast` with k≤4.
  - I is accepted and discarded.
  - `o_runt` pulses in the cycle after acceptance.
- **Case F, H valid and H last (its keep count k>4 is guaranteed):**
  - Output is H with `o_tlast=1` and `o_tkeep` = ones in bits [k-5:0].
  - `o_crc` = H bytes k-1..k-4.
  - `i_tready=o_tready`. On handshake, H loads I if I is valid, otherwise H becomes empty.
- Keep count is computed as the position of the highest set `tkeep` bit plus 1, as a 7-bit value in 0..64.
- A "first beat" flag is set at reset and after every `i_tlast` acceptance. It is cleared on acceptance of a non-last beat.

## Timing
- Reset: H is cleared and the first-beat flag is set. As a result `o_tvalid=0`, `o_tlast=0`, `o_tkeep=0`, `o_tdata=0`, `o_crc=0`, `o_runt=0` and `o_keep_err=0`. `i_tready` is 1 after reset.
- Assertion of `arst_n` mid-packet discards H and any partial packet immediately. No output is produced for that packet.
- Latency: one accepted beat. A non-last beat is emitted at the earliest in the cycle its successor arrives. A last beat held in H is emitted without waiting for further input.
- Throughput: one beat per clock with `o_tready` held high and back-to-back packets. There are no bubbles between packets.
- AXI rule: `o_tvalid` never depends on `o_tready`. Once asserted, `o_tdata`, `o_tkeep`, `o_tlast` and `o_crc` stay stable until the handshake, provided the source holds I stable as AXI requires.
- Simultaneous events: in Case F, handshakes on I and O in the same cycle load the new beat into H with no idle cycle.

## Configuration
- `AXIS_CRC_STRIP_KEEP_CHECK_EN` defined:
  - The `o_keep_err` port exists.
  - It is set on acceptance of a non-last beat whose keep is not all ones, or of a last beat whose keep is non-contiguous or zero.
  - It is cleared only by reset.
  - Data handling is unchanged; keep count still uses the highest set bit.
- Not defined: the port and the checking logic are absent, and keep format is trusted.

## Test plan
- **72 B packet:** beat0 full, beat1 keep `0xFF`, `o_tready=1`. Expect two output beats; beat1 has `o_tlast=1`, `o_tkeep=0xF`, and `o_crc` = I beat1 [63:32].
- **130 B packet:** beat1 full, beat2 keep `0x3`. Expect beat1 out with `o_tlast=1`, `o_tkeep=0x3FFF_FFFF_FFFF_FFFF`, and `o_crc={beat2[15:0], beat1[511:496]}`. Beat2 is dropped and 2 beats total are emitted.
- **68 B packet:** beat1 keep `0xF`. Expect beat0 out with `o_tlast=1`, `o_tkeep` all ones, and `o_crc` = beat1[31:0].
- **Runt:** single beat with keep `0xF`. Expect no output beat and a one-cycle `o_runt` pulse. A following 72 B packet is processed normally.
- **Backpressure:** three back-to-back 72 B packets with `o_tready` toggling 1010…. Expect 6 output beats with correct data, keep, last and CRC, no reordering, and outputs stable during stalls.
- **Mid-packet reset:** drive `arst_n` low after beat0 of a 130 B packet. Expect `o_tvalid=0` immediately; after release, the next 72 B packet is output correctly.

Source files
------------

// File: rtl/axis_crc_strip.sv
// Strips the 4-byte CRC trailer from 512-bit AXI-ST packets and presents it on o_crc with the last beat.
// Latency: one accepted beat of lookahead; a held last beat leaves without waiting for more input.
// Backpressure: i_tready follows o_tready while H holds output-ready data, else 1. Option: AXIS_CRC_STRIP_KEEP_CHECK_EN.
module axis_crc_strip #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              arst_n,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic [KEEP_W-1:0] i_tkeep,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [DATA_W-1:0] o_tdata,
  output logic [KEEP_W-1:0] o_tkeep,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [31:0]       o_crc,
  output logic              o_runt
`ifdef AXIS_CRC_STRIP_KEEP_CHECK_EN
  ,output logic             o_keep_err
`endif
);

  localparam logic [KEEP_W-1:0] ALL_ONES = '1;

  function automatic logic [6:0] keep_count(input logic [KEEP_W-1:0] k);
    logic [6:0] c;
    c = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      if (k[b]) c = 7'(b + 1);
    end
    return c;
  endfunction

  logic [DATA_W-1:0] h_data;
  logic [KEEP_W-1:0] h_keep;
  logic              h_last;
  logic              h_vld;
  logic              first;

  logic [6:0]  i_cnt;
  logic [6:0]  h_cnt;
  logic        i_short;
  logic        runt_in;
  logic        acc;
  logic        hs_out;
  logic [63:0] crc_win;

  assign i_cnt   = keep_count(i_tkeep);
  assign h_cnt   = keep_count(h_keep);
  assign i_short = i_tlast && (i_cnt <= 7'd4);
  assign runt_in = first && i_short;
  assign acc     = i_tvalid && i_tready;
  assign hs_out  = o_tvalid && o_tready;
  // Straddling trailer: the top four bytes of H followed by the low four bytes of I.
  assign crc_win = {i_tdata[31:0], h_data[DATA_W-1:DATA_W-32]};

  always_comb begin
    o_tdata  = h_data;
    o_tvalid = 1'b0;
    o_tkeep  = '0;
    o_tlast  = 1'b0;
    o_crc    = '0;
    i_tready = 1'b1;
    if (h_vld) begin
      if (h_last) begin
        o_tvalid = 1'b1;
        o_tlast  = 1'b1;
        o_tkeep  = ALL_ONES >> (7'd68 - h_cnt);
        o_crc    = 32'(h_data >> {h_cnt - 7'd4, 3'b000});
        i_tready = o_tready;
      end else if (i_tvalid) begin
        o_tvalid = 1'b1;
        o_tkeep  = h_keep;
        i_tready = o_tready;
        if (i_short) begin
          o_tlast = 1'b1;
          o_tkeep = ALL_ONES >> (3'd4 - i_cnt[2:0]);
          o_crc   = 32'(crc_win >> {i_cnt[2:0], 3'b000});
        end
      end
    end
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      h_data <= '0;
      h_keep <= '0;
      h_last <= 1'b0;
      h_vld  <= 1'b0;
      first  <= 1'b1;
      o_runt <= 1'b0;
    end else begin
      o_runt <= acc && runt_in;
      if (acc) first <= i_tlast;
      if (!h_vld || (h_last && hs_out) || (!h_last && acc)) begin
        if (acc && !runt_in && !(h_vld && !h_last && i_short)) begin
          h_data <= i_tdata;
          h_keep <= i_tkeep;
          h_last <= i_tlast;
          h_vld  <= 1'b1;
        end else begin
          h_vld  <= 1'b0;
        end
      end
    end
  end

`ifdef AXIS_CRC_STRIP_KEEP_CHECK_EN
  logic keep_bad;
  assign keep_bad = i_tlast ? ((i_tkeep == '0) || ((i_tkeep & (i_tkeep + KEEP_W'(1))) != '0))
                            : (i_tkeep != ALL_ONES);

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) o_keep_err <= 1'b0;
    else if (acc && keep_bad) o_keep_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_axis_crc_strip.sv
// Randomized scoreboard bench for axis_crc_strip: packets are modelled as byte arrays,
// expected output beats are queued at issue time and checked by an independent monitor.
module tb_axis_crc_strip;

  logic         clock = 1'b0;
  logic         arst_n = 1'b0;
  logic [511:0] i_tdata = '0;
  logic [63:0]  i_tkeep = '0;
  logic         i_tlast = 1'b0;
  logic         i_tvalid = 1'b0;
  logic         i_tready;
  logic [511:0] o_tdata;
  logic [63:0]  o_tkeep;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready = 1'b1;
  logic [31:0]  o_crc;
  logic         o_runt;

  axis_crc_strip dut (
    .clock(clock), .arst_n(arst_n),
    .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_crc(o_crc), .o_runt(o_runt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [31:0]  crc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   runt_exp = 0;
  int   runt_seen = 0;
  int   rdy_mode = 0;
  bit   gaps = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] kmask(input int c);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < c; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [511:0] bmask(input logic [63:0] k);
    logic [511:0] m;
    for (int i = 0; i < 64; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Sink ready pattern: 0 always ready, 1 toggling, 2 random, 3 stalled.
  initial begin
    forever begin
      @(posedge clock); #1;
      case (rdy_mode)
        0:       o_tready = 1'b1;
        1:       o_tready = ~o_tready;
        2:       o_tready = ($urandom_range(0, 3) != 0);
        default: o_tready = 1'b0;
      endcase
    end
  end

  // Monitor
  bit           stalled = 0;
  logic [511:0] s_data;
  logic [63:0]  s_keep;
  logic         s_last;
  logic [31:0]  s_crc;

  always @(negedge clock) begin
    if (!arst_n) begin
      stalled = 0;
    end else begin
      if (o_runt) runt_seen++;
      if (stalled) begin
        check("stall_stable", {o_tvalid, o_tlast, o_tkeep, o_crc, o_tdata[63:0]},
              {1'b1, s_last, s_keep, s_crc, s_data[63:0]});
        check("stall_data", o_tdata, s_data);
      end
      if (o_tvalid && o_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {511'd0, o_tvalid}, 512'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_keep", {448'd0, o_tkeep}, {448'd0, e.keep});
          check("out_last", {511'd0, o_tlast}, {511'd0, e.last});
          check("out_data", o_tdata & bmask(e.keep), e.data & bmask(e.keep));
          if (e.last) check("out_crc", {480'd0, o_crc}, {480'd0, e.crc});
        end
      end
      stalled = o_tvalid && !o_tready;
      s_data = o_tdata; s_keep = o_tkeep; s_last = o_tlast; s_crc = o_crc;
    end
  end

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    bit acc;
    int t;
    acc = 0;
    t = 0;
    i_tdata = d; i_tkeep = k; i_tlast = l; i_tvalid = 1'b1;
    while (!acc && t < 500) begin
      @(negedge clock);
      acc = i_tready;
      @(posedge clock); #1;
      t++;
    end
    if (!acc) check("in_accept_timeout", 512'd0, 512'd1);
    i_tvalid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
  endtask

  // Builds packet of n bytes (CRC included); pushes expectations; abort sends only beat 0.
  task automatic send_packet(input int n, input bit abort);
    logic [7:0]   pkt[$];
    logic [511:0] bd[$];
    logic [511:0] d;
    int nb, plen, nout;
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
    nb = (n + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
      for (int y = 0; y < 64; y++) if (64*b + y < n) d[8*y +: 8] = pkt[64*b + y];
      bd.push_back(d);
    end
    if (!abort) begin
      plen = n - 4;
      if (plen <= 0) begin
        runt_exp++;
      end else begin
        nout = (plen + 63) / 64;
        for (int j = 0; j < nout; j++) begin
          exp_t e;
          e.data = bd[j];
          e.keep = kmask((plen - 64*j > 64) ? 64 : plen - 64*j);
          e.last = (j == nout - 1);
          e.crc  = {pkt[n-1], pkt[n-2], pkt[n-3], pkt[n-4]};
          sb.push_back(e);
        end
      end
    end
    for (int b = 0; b < nb; b++) begin
      send_beat(bd[b], (b == nb - 1) ? kmask(n - 64*b) : '1, b == nb - 1);
      if (abort) break;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin @(posedge clock); #1; t++; end
    check("drain", {480'd0, 32'(sb.size())}, 512'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_tvalid", {511'd0, o_tvalid}, 512'd0);
    check("rst_tlast", {511'd0, o_tlast}, 512'd0);
    check("rst_tkeep", {448'd0, o_tkeep}, 512'd0);
    check("rst_tdata", o_tdata, 512'd0);
    check("rst_crc", {480'd0, o_crc}, 512'd0);
    check("rst_runt", {511'd0, o_runt}, 512'd0);
    @(negedge clock);
    arst_n = 1'b1;
    @(posedge clock); #1;
    check("rst_tready", {511'd0, i_tready}, {511'd0, 1'b1});

    // Directed boundary packets
    send_packet(72, 0);
    send_packet(130, 0);
    send_packet(68, 0);
    send_packet(4, 0);
    send_packet(72, 0);
    wait_drain();

    // Back-to-back under toggling backpressure
    rdy_mode = 1;
    repeat (3) send_packet(72, 0);
    wait_drain();

    // Mid-packet reset while a straddling beat is stalled at the output
    rdy_mode = 3;
    @(posedge clock); #1;
    send_packet(130, 1);
    i_tdata = {8{$urandom, $urandom}}; i_tkeep = 64'h3; i_tlast = 1'b1; i_tvalid = 1'b1;
    @(negedge clock);
    check("mid_pre_tvalid", {511'd0, o_tvalid}, {511'd0, 1'b1});
    #1 arst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", {511'd0, o_tvalid}, 512'd0);
    i_tvalid = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    arst_n = 1'b1;
    @(posedge clock); #1;
    send_packet(72, 0);
    wait_drain();

    // Random traffic
    gaps = 1;
    rdy_mode = 2;
    for (int p = 0; p < 200; p++) begin
      int n;
      case ($urandom_range(0, 3))
        0: n = $urandom_range(1, 8);
        1: n = $urandom_range(60, 72);
        2: n = $urandom_range(124, 136);
        default: n = $urandom_range(1, 300);
      endcase
      send_packet(n, 0);
    end
    wait_drain();
    repeat (4) @(posedge clock);
    #1;
    check("runt_count", {480'd0, 32'(runt_seen)}, {480'd0, 32'(runt_exp)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
